// File: rtl/bram_pixel_stream_out.sv
// Streams one frame of nine-lane lattice pixels out of the lattice BRAM as
// 144-bit AXI4-Stream beats. A 4-entry FIFO absorbs the one-cycle BRAM read latency.
module bram_pixel_stream_out #(
  parameter int DATA_WIDTH             = 16,
  parameter int DEPTH                  = 2500,
  parameter int ADDRESS_WIDTH          = 12,
  parameter int C_M00_AXIS_TDATA_WIDTH = 144
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_areset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  ren,
  output logic [ADDRESS_WIDTH-1:0]              rd_addr,
  input  logic [DATA_WIDTH-1:0]                 rd_n,
  input  logic [DATA_WIDTH-1:0]                 rd_null,
  input  logic [DATA_WIDTH-1:0]                 rd_ne,
  input  logic [DATA_WIDTH-1:0]                 rd_e,
  input  logic [DATA_WIDTH-1:0]                 rd_se,
  input  logic [DATA_WIDTH-1:0]                 rd_s,
  input  logic [DATA_WIDTH-1:0]                 rd_sw,
  input  logic [DATA_WIDTH-1:0]                 rd_w,
  input  logic [DATA_WIDTH-1:0]                 rd_nw,
  output logic [ADDRESS_WIDTH-1:0]              read_addr,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam int TW = C_M00_AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [CW-1:0]   r_issue_idx;
  logic [CW-1:0]   r_read_cnt;
  logic            r_inflight;
  logic            r_cap_last;

  logic [TW-1:0]   r_fifo_data [4];
  logic            r_fifo_last [4];
  logic [1:0]      r_wr_ptr;
  logic [1:0]      r_rd_ptr;
  logic [2:0]      r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_run_entry;
  logic            w_credit_ok;
  logic            w_issue_ok;
  logic            w_last_pop;
  logic [TW-1:0]   w_packed;
  logic            w_unused_cnt_msb;

  assign w_packed    = {rd_nw, rd_w, rd_sw, rd_s, rd_se, rd_e, rd_ne, rd_null, rd_n};
  assign w_push      = r_inflight;
  assign w_pop       = m00_axis_tvalid && m00_axis_tready;
  assign w_last_pop  = w_pop && m00_axis_tlast;
  assign w_run_entry = (r_state == S_IDLE) && start;
  // Credit counts both queued entries and the read still on its way back from BRAM.
  assign w_credit_ok = (r_count + {2'b00, r_inflight}) < 3'd4;
  assign w_issue_ok  = r_issue_idx < CW'(DEPTH);

  // FSM: state register
  always_ff @(posedge m00_axis_aclk) begin
    // NOTE: all clocked state uses non-blocking assignment so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (m00_axis_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last_pop) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    ren  = 1'b0;
    unique case (r_state)
      S_RUN:   begin
        busy = 1'b1;
        ren  = w_issue_ok && w_credit_ok;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Read issue, in-flight tracking and accepted-beat counter
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      r_issue_idx <= '0;
      r_read_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_cap_last  <= 1'b0;
    end else begin
      r_inflight <= ren;
      r_cap_last <= ren && (r_issue_idx == CW'(DEPTH - 1));
      if (w_run_entry) begin
        r_issue_idx <= '0;
      end else if (ren) begin
        r_issue_idx <= r_issue_idx + CW'(1);
      end
      if (w_run_entry) begin
        r_read_cnt <= '0;
      end else if (w_pop) begin
        r_read_cnt <= r_read_cnt + CW'(1);
      end
    end
  end

  // FIFO control
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge m00_axis_aclk) begin
    // NOTE: payload storage is deliberately not reset; the pointers and count are,
    // and the outputs are gated by occupancy so stale entries are never visible.
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_packed;
      r_fifo_last[r_wr_ptr] <= r_cap_last;
    end
  end

  assign m00_axis_tvalid  = (r_count != 3'd0);
  assign m00_axis_tdata   = m00_axis_tvalid ? r_fifo_data[r_rd_ptr] : '0;
  assign m00_axis_tlast   = m00_axis_tvalid && r_fifo_last[r_rd_ptr];
  assign m00_axis_tstrb   = '1;

  assign rd_addr          = r_issue_idx[ADDRESS_WIDTH-1:0];
  assign read_addr        = r_read_cnt[ADDRESS_WIDTH-1:0];
  assign w_unused_cnt_msb = r_read_cnt[ADDRESS_WIDTH];

endmodule

// File: tb/tb_bram_pixel_stream_out.sv
// Directed bench for bram_pixel_stream_out: a full 2500-pixel instance and a
// 4-pixel instance, each fed by a one-cycle-latency BRAM model (lane k = pixel + k).
module tb_bram_pixel_stream_out;

  localparam int DEPTH_A = 2500;
  localparam int AW_A    = 12;
  localparam int DEPTH_B = 4;
  localparam int AW_B    = 3;
  localparam int TW      = 144;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // Instance A signals
  logic            a_areset, a_start, a_busy, a_done, a_ren;
  logic [AW_A-1:0] a_rd_addr, a_read_addr;
  logic [15:0]     a_q;
  logic            a_tvalid, a_tlast, a_tready;
  logic [TW-1:0]   a_tdata;
  logic [TW/8-1:0] a_tstrb;

  // Instance B signals
  logic            b_areset, b_start, b_busy, b_done, b_ren;
  logic [AW_B-1:0] b_rd_addr, b_read_addr;
  logic [15:0]     b_q;
  logic            b_tvalid, b_tlast, b_tready;
  logic [TW-1:0]   b_tdata;
  logic [TW/8-1:0] b_tstrb;

  bram_pixel_stream_out #(
    .DATA_WIDTH(16), .DEPTH(DEPTH_A), .ADDRESS_WIDTH(AW_A), .C_M00_AXIS_TDATA_WIDTH(TW)
  ) u_dut_a (
    .m00_axis_aclk(clk), .m00_axis_areset(a_areset), .start(a_start),
    .busy(a_busy), .done(a_done), .ren(a_ren), .rd_addr(a_rd_addr),
    .rd_n(a_q), .rd_null(a_q + 16'd1), .rd_ne(a_q + 16'd2), .rd_e(a_q + 16'd3),
    .rd_se(a_q + 16'd4), .rd_s(a_q + 16'd5), .rd_sw(a_q + 16'd6), .rd_w(a_q + 16'd7),
    .rd_nw(a_q + 16'd8), .read_addr(a_read_addr),
    .m00_axis_tvalid(a_tvalid), .m00_axis_tdata(a_tdata), .m00_axis_tstrb(a_tstrb),
    .m00_axis_tlast(a_tlast), .m00_axis_tready(a_tready)
  );

  bram_pixel_stream_out #(
    .DATA_WIDTH(16), .DEPTH(DEPTH_B), .ADDRESS_WIDTH(AW_B), .C_M00_AXIS_TDATA_WIDTH(TW)
  ) u_dut_b (
    .m00_axis_aclk(clk), .m00_axis_areset(b_areset), .start(b_start),
    .busy(b_busy), .done(b_done), .ren(b_ren), .rd_addr(b_rd_addr),
    .rd_n(b_q), .rd_null(b_q + 16'd1), .rd_ne(b_q + 16'd2), .rd_e(b_q + 16'd3),
    .rd_se(b_q + 16'd4), .rd_s(b_q + 16'd5), .rd_sw(b_q + 16'd6), .rd_w(b_q + 16'd7),
    .rd_nw(b_q + 16'd8), .read_addr(b_read_addr),
    .m00_axis_tvalid(b_tvalid), .m00_axis_tdata(b_tdata), .m00_axis_tstrb(b_tstrb),
    .m00_axis_tlast(b_tlast), .m00_axis_tready(b_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: the word for pixel i carries i+k in lane k, one cycle after ren
  always_ff @(posedge clk) begin
    if (a_ren) a_q <= 16'(a_rd_addr);
    if (b_ren) b_q <= 16'(b_rd_addr);
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [TW-1:0] exp_word(input int i);
    logic [TW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[16*k +: 16] = 16'(i + k);
    return w;
  endfunction

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"},      a_busy, 0);
    check({tag, "_done"},      a_done, 0);
    check({tag, "_ren"},       a_ren, 0);
    check({tag, "_tvalid"},    a_tvalid, 0);
    check({tag, "_tlast"},     a_tlast, 0);
    check({tag, "_rd_addr"},   a_rd_addr, 0);
    check({tag, "_read_addr"}, a_read_addr, 0);
    check({tag, "_tdata"},     a_tdata, 0);
    check({tag, "_tstrb"},     a_tstrb, {(TW/8){1'b1}});
  endtask

  // mode 0: tready=1, mode 1: random 50%, mode 2: stall 10 cycles on the tlast beat.
  // poke_start pulses start at beat 100; abort_at >= 0 returns once that many beats are accepted.
  task automatic frame_a(input int mode, input bit poke_start, input int abort_at);
    int beat, issued, cyc, first_valid, stall, fifo, inflight;
    bit fin, poked, prev_ren, prev_stalled, prev_last;
    logic [TW-1:0] prev_data;
    beat = 0; issued = 0; first_valid = -1; stall = 0;
    fin = 0; poked = 0; prev_ren = 0; prev_stalled = 0; prev_last = 0; prev_data = '0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    cyc = 1;
    check("a_start_busy", a_busy, 1);
    check("a_start_ren", a_ren, 1);
    check("a_start_rd_addr", a_rd_addr, 0);
    while (!fin && cyc < 4 * DEPTH_A + 50) begin
      if (abort_at >= 0 && beat == abort_at) return;
      a_start  = 1'b0;
      inflight = prev_ren ? 1 : 0;
      fifo     = issued - inflight - beat;
      check("a_occupancy_le4", fifo <= 4, 1);
      check("a_tvalid_vs_occ", a_tvalid, fifo > 0);
      check("a_read_addr_run", a_read_addr, beat);
      check("a_busy_run", a_busy, 1);
      if (a_ren) begin
        check("a_credit", (issued - beat) < 4, 1);
        check("a_rd_addr_seq", a_rd_addr, issued);
      end
      if (prev_stalled) begin
        check("a_hold_tvalid", a_tvalid, 1);
        check("a_hold_tdata", a_tdata, prev_data);
        check("a_hold_tlast", a_tlast, prev_last);
      end
      case (mode)
        1:       a_tready = 1'($urandom_range(0, 1));
        2:       if (a_tvalid && a_tlast && stall < 10) begin
                   a_tready = 1'b0;
                   stall++;
                 end else a_tready = 1'b1;
        default: a_tready = 1'b1;
      endcase
      if (poke_start && !poked && beat == 100) begin
        a_start = 1'b1;
        poked   = 1'b1;
      end
      if (a_tvalid && a_tready) begin
        check("a_beat_tdata", a_tdata, exp_word(beat));
        check("a_beat_tlast", a_tlast, beat == DEPTH_A - 1);
        if (beat == 0) first_valid = cyc;
        if (beat == DEPTH_A - 1) fin = 1'b1;
        beat++;
      end
      prev_stalled = a_tvalid && !a_tready;
      prev_data    = a_tdata;
      prev_last    = a_tlast;
      prev_ren     = a_ren;
      if (a_ren) issued++;
      step();
      cyc++;
    end
    a_start = 1'b0;
    check("a_beat_count", beat, DEPTH_A);
    check("a_done_pulse", a_done, 1);
    check("a_busy_after", a_busy, 0);
    check("a_tvalid_after", a_tvalid, 0);
    check("a_read_addr_end", a_read_addr, DEPTH_A);
    if (mode == 2) check("a_stall_cycles", stall, 10);
    if (mode == 0) begin
      check("a_first_valid_cycle", first_valid, 3);
      check("a_done_cycle", cyc, DEPTH_A + 3);
    end
    step();
    check("a_done_single", a_done, 0);
    check("a_read_addr_hold", a_read_addr, DEPTH_A);
  endtask

  task automatic frame_b();
    int beat, cyc;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    check("b_read_addr_clear", b_read_addr, 0);
    check("b_busy", b_busy, 1);
    beat = 0;
    cyc  = 1;
    while (beat < DEPTH_B && cyc < 40) begin
      check("b_read_addr_run", b_read_addr, beat);
      if (b_tvalid) begin
        check("b_tdata", b_tdata, exp_word(beat));
        check("b_tlast", b_tlast, beat == DEPTH_B - 1);
        beat++;
      end
      step();
      cyc++;
    end
    check("b_beat_count", beat, DEPTH_B);
    check("b_done_cycle", cyc, DEPTH_B + 3);
    check("b_done", b_done, 1);
    check("b_read_addr_end", b_read_addr, DEPTH_B);
    step();
    check("b_done_single", b_done, 0);
    check("b_read_addr_hold", b_read_addr, DEPTH_B);
  endtask

  initial begin
    a_areset = 1'b1; a_start = 1'b0; a_tready = 1'b1;
    b_areset = 1'b1; b_start = 1'b0; b_tready = 1'b1;
    step(); step(); step();
    check_reset_a("rst");
    check("rst_b_tvalid", b_tvalid, 0);
    check("rst_b_read_addr", b_read_addr, 0);
    a_areset = 1'b0;
    b_areset = 1'b0;
    step();
    check_reset_a("idle");

    frame_a(0, 1'b0, -1);   // full frame, no backpressure
    frame_a(1, 1'b0, -1);   // random backpressure
    frame_a(2, 1'b0, -1);   // stall on the last beat
    frame_a(0, 1'b1, -1);   // start pulsed while busy

    frame_a(0, 1'b0, 1000); // reset mid-frame
    a_areset = 1'b1;
    step();
    check_reset_a("midrst");
    a_areset = 1'b0;
    step();
    check_reset_a("midrst_idle");
    frame_a(0, 1'b0, -1);

    frame_b();              // small back-to-back frames
    frame_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_pixel_stream_out.md
# bram_pixel_stream_out

Reads the nine 16-bit lattice distributions of every pixel from the lattice BRAM read port, packs them into one 144-bit word per pixel and emits a DEPTH-beat AXI4-Stream frame toward DDR. It sits directly upstream of the pixel write-back stage. It feeds that stage's `m00_axis_*` inputs and exports the running count of accepted pixels as `read_addr`, which bounds that stage's `write_addr`. A 4-entry output FIFO hides the one-cycle BRAM read latency, so the block sustains one beat per cycle under continuous `tready`.

## Interface
- DATA_WIDTH, 16, width of one distribution value
- DEPTH, 2500, pixels per frame
- ADDRESS_WIDTH, 12, BRAM address width; must satisfy DEPTH ≤ 2^ADDRESS_WIDTH
- C_M00_AXIS_TDATA_WIDTH, 144, equals 9×DATA_WIDTH
- m00_axis_aclk  in  1  single clock; all logic is on the rising edge
- m00_axis_areset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE
- busy  out  1  high from RUN entry until the last beat is accepted
- done  out  1  one-cycle pulse in the cycle after the last beat handshake
- ren  out  1  BRAM read enable
- rd_addr  out  ADDRESS_WIDTH  BRAM read address (pixel index)
- rd_n, rd_null, rd_ne, rd_e, rd_se, rd_s, rd_sw, rd_w, rd_nw  in  DATA_WIDTH each  BRAM read data, valid in the cycle after `ren`
- read_addr  out  ADDRESS_WIDTH  count of beats accepted in the current frame
- m00_axis_tvalid  out  1
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all ones
- m00_axis_tlast  out  1
- m00_axis_tready  in  1

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1.
  - RUN→DONE in the cycle after the handshake of the beat with index DEPTH-1.
  - DONE→IDLE unconditionally. `done`=1 while in DONE.
- **Read issue:** in RUN, `ren`=1 when `issue_idx < DEPTH` and `fifo_count + inflight < 4`. `rd_addr` = `issue_idx`, which then increments.
- **In-flight tracking:** `inflight` counts reads issued whose data has not yet been written to the FIFO (0..1 with one-cycle latency).
- **Capture:** the cycle after `ren`, the nine inputs are written into the FIFO with `rd_n` at [15:0], then null, ne, e, se, s, sw, w, and `rd_nw` at [143:128]. Each entry also stores a last flag, set when its index is DEPTH-1.
- **Output:**
  - `tvalid` = FIFO non-empty.
  - `tdata`/`tlast` come from the FIFO head.
  - On `tvalid`&&`tready` the head pops and `read_addr` increments.
- **Handshake rules:**
  - Once `tvalid` is asserted, it and `tdata` stay stable until the handshake.
  - No combinational path from `tready` to `tvalid`.
- **Simultaneous push and pop:** `fifo_count` is unchanged; the FIFO never overflows because of the credit rule.
- **`start` outside IDLE:** ignored.
- **Frame boundary:**
  - On RUN entry, `issue_idx` and `read_addr` clear to 0.
  - `read_addr` holds DEPTH after the frame until the next start.
- **Address width:** `issue_idx` and `read_addr` are ADDRESS_WIDTH+1 bits internally so the DEPTH value is representable. Only the low ADDRESS_WIDTH bits of `read_addr` appear on the port.

## Timing
- **Reset values:**
  - `busy`, `done`, `ren`, `tvalid`, `tlast` = 0.
  - `rd_addr`, `read_addr`, `tdata` = 0.
  - `tstrb` = all ones.
  - FSM = IDLE; FIFO and `inflight` cleared.
- **Start latency:** with `start` in cycle 0:
  - RUN and `busy` begin in cycle 1.
  - `ren`/`rd_addr`=0 in cycle 1.
  - Data is captured at the end of cycle 2.
  - First `tvalid` in cycle 3.
- **Throughput:** with `tready` held at 1, one beat per cycle. The last beat is in cycle DEPTH+2; `done` is in cycle DEPTH+3.
- **Backpressure:** with `tready`=0 the FIFO fills to 4 and `ren` then stays 0. Issuing resumes in the cycle after a pop.
- **Reset mid-frame:** everything returns to reset values at the next edge; in-flight BRAM data is discarded.

## Test plan
- **Full frame, no backpressure:** DEPTH=2500, `tready`=1, BRAM word for pixel i holds value i+k in lane k.
  - 2500 beats, each with the correct lane packing.
  - `tlast` only on beat 2499.
  - First `tvalid` 3 cycles after `start`; `done` in cycle 2503.
  - `read_addr` ends at 2500.
- **Random backpressure:** `tready` random at 50%.
  - No beat lost or duplicated.
  - `tdata` stable while stalled.
  - FIFO occupancy never above 4.
  - `ren` never asserted while `fifo_count + inflight` = 4.
- **Stall on last beat:** `tready`=0 for 10 cycles while the beat with `tlast` is presented.
  - `tlast`/`tvalid` held.
  - `done` pulses exactly once, the cycle after acceptance.
- **Start while busy:** `start` pulsed at beat 100.
  - Frame unaffected; 2500 beats total.
- **Reset mid-frame:** reset at beat 1000.
  - All outputs return to reset values.
  - A new `start` yields a clean frame from pixel 0.
- **Small frame:** DEPTH=4, with back-to-back frames.
  - 4 beats per frame.
  - `read_addr` goes 0..4 and clears on the next RUN entry.
